// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encoding, requester IDs and defaults for dmem_arbiter.
package dmem_arbiter_pkg;
    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} arb_state_t;
    typedef enum logic {ID_CPU = 1'b0, ID_DMA = 1'b1} req_id_t;
    localparam int ADDR_W_DEFAULT = 14;
    localparam int MAX_BURST_DEFAULT = 16;
    localparam int BURST_CNT_W = 8;
    localparam logic [3:0] WEA_NONE = 4'b0000;
    function automatic logic is_read(input logic [3:0] wea);
        return wea == WEA_NONE;
    endfunction
endpackage

// File: rtl/dmem_arbiter_arb_rr2.sv
// arb_rr2: two-way round-robin pick; on contention the requester not granted last wins.
module arb_rr2 import dmem_arbiter_pkg::*; (
    input  logic    clk,
    input  logic    rst,
    input  logic    cpu_req,
    input  logic    dma_req,
    input  logic    gnt,
    input  req_id_t gnt_id,
    output req_id_t pick
);
    req_id_t last_gnt;
    always_ff @(posedge clk) begin
        if (!rst) last_gnt <= ID_DMA;
        else if (gnt) last_gnt <= gnt_id;
    end
    always_comb begin
        pick = (cpu_req && dma_req) ? (last_gnt == ID_CPU ? ID_DMA : ID_CPU)
                                    : (dma_req ? ID_DMA : ID_CPU);
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter for one shared data BRAM port with DMA burst locking.
// DMEM_ARB_BURST_LIMIT_EN bounds a locked burst to MAX_BURST grants while the CPU waits.
module dmem_arbiter import dmem_arbiter_pkg::*; #(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wea,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_adr,
    input  logic [31:0]       dma_wdata,
    input  logic [3:0]        dma_wea,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_din,
    output logic [3:0]        mem_wea,
    input  logic [31:0]       mem_dout
);
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST out of range 1..255");
    end

    arb_state_t state, state_nx;
    req_id_t    pick;
    logic       burst_hit;

`ifdef DMEM_ARB_BURST_LIMIT_EN
    logic [BURST_CNT_W-1:0] burst_cnt;
    assign burst_hit = burst_cnt == BURST_CNT_W'(MAX_BURST);
    // saturates so an idle CPU never lets the count wrap past the limit
    always_ff @(posedge clk) begin
        if (!rst) burst_cnt <= '0;
        else if (dma_gnt) burst_cnt <= state == IDLE ? BURST_CNT_W'(1) : (burst_hit ? burst_cnt : burst_cnt + 1'b1);
    end
`else
    assign burst_hit = 1'b0;
`endif

    arb_rr2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .cpu_req(cpu_req),
        .dma_req(dma_req),
        .gnt    (cpu_gnt | dma_gnt),
        .gnt_id (dma_gnt ? ID_DMA : ID_CPU),
        .pick   (pick)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cpu_gnt  = 1'b0;
        dma_gnt  = 1'b0;
        if (rst) begin
            if (state == IDLE) begin
                cpu_gnt = cpu_req && pick == ID_CPU;
                dma_gnt = dma_req && pick == ID_DMA;
                if (dma_gnt && dma_lock) state_nx = LOCK;
            end else if (burst_hit && cpu_req) begin
                cpu_gnt  = 1'b1;
                state_nx = IDLE;
            end else begin
                dma_gnt = dma_req;
                if (!dma_lock || (!dma_req && cpu_req)) state_nx = IDLE;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign mem_adr   = dma_gnt ? dma_adr : cpu_adr;
    assign mem_din   = dma_gnt ? dma_wdata : cpu_wdata;
    assign mem_wea   = cpu_gnt ? cpu_wea : (dma_gnt ? dma_wea : WEA_NONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt && is_read(cpu_wea);
            dma_rvalid <= dma_gnt && is_read(dma_wea);
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a write-first BRAM and reference memory.
module tb_dmem_arbiter;
    localparam int ADDR_W = 14;
    typedef struct packed { logic port; logic [31:0] data; } sb_t;

    logic              clk = 1'b0, rst = 1'b0;
    logic              cpu_req = 1'b0, dma_req = 1'b0, dma_lock = 1'b0;
    logic [ADDR_W-1:0] cpu_adr = '0, dma_adr = '0;
    logic [31:0]       cpu_wdata = '0, dma_wdata = '0;
    logic [3:0]        cpu_wea = '0, dma_wea = '0;
    logic              cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [ADDR_W-1:0] mem_adr;
    logic [31:0]       mem_din, mem_dout;
    logic [3:0]        mem_wea;

    logic [31:0] bram [1<<ADDR_W];
    logic [31:0] ref_mem [1<<ADDR_W];
    sb_t         sb_q [$];
    int          total = 0, bad = 0;
    bit          done = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_wea(cpu_wea),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_adr(dma_adr), .dma_wdata(dma_wdata), .dma_wea(dma_wea),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .mem_adr(mem_adr), .mem_din(mem_din), .mem_wea(mem_wea), .mem_dout(mem_dout)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0; cpu_wea = 4'h0; dma_wea = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_req = 1'b1; dma_req = 1'b1;
        tick(); tick(); #1;
        total++;
        if ({cpu_gnt, dma_gnt, mem_wea, cpu_rvalid, dma_rvalid} !== 8'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want 00000000", {cpu_gnt, dma_gnt, mem_wea, cpu_rvalid, dma_rvalid});
        end
        total++;
        if (cpu_stall !== 1'b1) begin bad++; $display("FAIL reset_stall: got %b want 1", cpu_stall); end
    endtask

    task automatic test_contention();
        rst = 1'b1; cpu_adr = ADDR_W'(16'h10); dma_adr = ADDR_W'(16'h30);
        #1; total++;
        if ({cpu_gnt, dma_gnt} !== 2'b10) begin bad++; $display("FAIL first_contention: got %b want 10", {cpu_gnt, dma_gnt}); end
        tick(); #1; total++;
        if ({cpu_gnt, dma_gnt, cpu_stall} !== 3'b011) begin bad++; $display("FAIL second_contention: got %b want 011", {cpu_gnt, dma_gnt, cpu_stall}); end
        tick(); dma_req = 1'b0; #1; total++;
        if ({cpu_gnt, dma_gnt, cpu_stall} !== 3'b100) begin bad++; $display("FAIL cpu_after_dma: got %b want 100", {cpu_gnt, dma_gnt, cpu_stall}); end
        tick(); idle_inputs();
    endtask

    task automatic test_cpu_rw();
        cpu_req = 1'b1; cpu_adr = ADDR_W'(16'h10); cpu_wdata = 32'hDEADBEEF; cpu_wea = 4'hF;
        #1; total++;
        if ({cpu_gnt, cpu_stall, mem_wea, mem_adr} !== {2'b10, 4'hF, ADDR_W'(16'h10)}) begin
            bad++; $display("FAIL cpu_write: got gnt/stall/wea/adr %b/%b/%h/%h", cpu_gnt, cpu_stall, mem_wea, mem_adr);
        end
        tick(); cpu_wea = 4'h0; #1; total++;
        if ({cpu_gnt, cpu_stall} !== 2'b10) begin bad++; $display("FAIL cpu_read_gnt: got %b want 10", {cpu_gnt, cpu_stall}); end
        tick(); cpu_req = 1'b0; #1; total++;
        if ({cpu_rvalid, dma_rvalid, mem_dout} !== {2'b10, 32'hDEADBEEF}) begin
            bad++; $display("FAIL cpu_read_data: got rv %b data %h want 10 deadbeef", {cpu_rvalid, dma_rvalid}, mem_dout);
        end
        tick();
    endtask

    task automatic test_burst();
        cpu_req = 1'b1; cpu_adr = ADDR_W'(16'h21); cpu_wdata = 32'h12345678; cpu_wea = 4'hF;
        tick();
        cpu_adr = ADDR_W'(16'h40); cpu_wea = 4'h0; dma_req = 1'b1; dma_wea = 4'h0;
        for (int i = 0; i < 4; i++) begin
            dma_adr = ADDR_W'(32'h20 + i); dma_lock = i < 3;
            #1; total++;
            if ({dma_gnt, cpu_gnt, cpu_stall} !== 3'b101) begin bad++; $display("FAIL burst_gnt[%0d]: got %b want 101", i, {dma_gnt, cpu_gnt, cpu_stall}); end
            if (i > 0) begin
                total++;
                if (dma_rvalid !== 1'b1) begin bad++; $display("FAIL burst_rvalid[%0d]: got %b want 1", i, dma_rvalid); end
            end
            if (i == 2) begin
                total++;
                if (mem_dout !== 32'h12345678) begin bad++; $display("FAIL burst_data: got %h want 12345678", mem_dout); end
            end
            tick();
        end
        dma_req = 1'b0; dma_lock = 1'b0; #1; total++;
        if ({cpu_gnt, dma_rvalid} !== 2'b11) begin bad++; $display("FAIL burst_release: got %b want 11", {cpu_gnt, dma_rvalid}); end
        tick(); idle_inputs(); tick();
    endtask

    task automatic test_long_lock();
        int  run;
        logic exp_c;
        cpu_req = 1'b1; cpu_adr = '0; cpu_wea = 4'h0;
        tick();
        dma_req = 1'b1; dma_lock = 1'b1; dma_adr = ADDR_W'(16'h50); dma_wea = 4'h0;
        run = 0;
        for (int i = 0; i < 40; i++) begin
`ifdef DMEM_ARB_BURST_LIMIT_EN
            exp_c = run == 16;
`else
            exp_c = 1'b0;
`endif
            #1; total++;
            if ({cpu_gnt, dma_gnt} !== {exp_c, ~exp_c}) begin bad++; $display("FAIL long_lock[%0d]: got %b want %b", i, {cpu_gnt, dma_gnt}, {exp_c, ~exp_c}); end
            run = exp_c ? 0 : run + 1;
            tick();
        end
        dma_req = 1'b0; dma_lock = 1'b0;
        tick(); tick(); idle_inputs(); tick();
    endtask

    task automatic test_reset_mid_burst();
        cpu_req = 1'b1; cpu_adr = ADDR_W'(16'h60); cpu_wdata = 32'hA5A5_0001; cpu_wea = 4'hF;
        tick();
        cpu_wea = 4'h0; dma_req = 1'b1; dma_lock = 1'b1; dma_adr = ADDR_W'(16'h60); dma_wea = 4'h0;
        tick(); tick();
        rst = 1'b0; #1; total++;
        if ({cpu_gnt, dma_gnt, mem_wea} !== 6'b0) begin bad++; $display("FAIL mid_reset_gnt: got %b want 000000", {cpu_gnt, dma_gnt, mem_wea}); end
        tick(); #1; total++;
        if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_wea} !== 8'b0) begin
            bad++; $display("FAIL mid_reset_next: got %b want 00000000", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_wea});
        end
        rst = 1'b1; dma_lock = 1'b0; #1; total++;
        if ({cpu_gnt, dma_gnt} !== 2'b10) begin bad++; $display("FAIL post_reset_contention: got %b want 10", {cpu_gnt, dma_gnt}); end
        tick(); cpu_req = 1'b0; #1; total++;
        if (dma_gnt !== 1'b1) begin bad++; $display("FAIL post_reset_dma: got %b want 1", dma_gnt); end
        tick(); idle_inputs(); tick();
    endtask

    task automatic test_random();
        logic cg = 1'b0, dg = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!cpu_req || cg) begin
                cpu_req = $urandom_range(0, 2) != 0; cpu_adr = ADDR_W'($urandom_range(0, 15));
                cpu_wdata = $urandom; cpu_wea = $urandom_range(0, 1) != 0 ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            if (!dma_req || dg) begin
                dma_req = $urandom_range(0, 2) != 0; dma_adr = ADDR_W'($urandom_range(0, 15));
                dma_wdata = $urandom; dma_wea = $urandom_range(0, 1) != 0 ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            dma_lock = $urandom_range(0, 3) != 0;
            #1; cg = cpu_gnt; dg = dma_gnt; total++;
            if (cpu_stall !== (cpu_req & ~cpu_gnt)) begin bad++; $display("FAIL rand_stall[%0d]: got %b want %b", i, cpu_stall, cpu_req & ~cpu_gnt); end
            tick();
        end
        idle_inputs(); tick(); tick();
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) begin bram[a] = '0; ref_mem[a] = '0; end
        mem_dout = '0;
        fork
            begin : stimulus
                test_reset();
                test_contention();
                test_cpu_rw();
                test_burst();
                test_long_lock();
                test_reset_mid_burst();
                test_random();
                done = 1'b1;
            end
            begin : ram
                logic [31:0] w;
                while (!done) begin
                    @(posedge clk);
                    w = bram[mem_adr];
                    for (int k = 0; k < 4; k++) if (mem_wea[k]) w[k*8 +: 8] = mem_din[k*8 +: 8];
                    if (mem_wea != 4'h0) bram[mem_adr] = w;
                    mem_dout = w;
                end
            end
            begin : monitor
                logic ec, ed;
                logic [3:0] ew;
                sb_t e;
                while (!done) begin
                    @(negedge clk);
                    total++;
                    if (cpu_gnt && dma_gnt) begin bad++; $display("FAIL double_grant: got cpu=%b dma=%b", cpu_gnt, dma_gnt); end
                    total++;
                    if ((cpu_gnt && !cpu_req) || (dma_gnt && !dma_req)) begin
                        bad++; $display("FAIL spurious_grant: gnt %b req %b", {cpu_gnt, dma_gnt}, {cpu_req, dma_req});
                    end
                    ew = cpu_gnt ? cpu_wea : (dma_gnt ? dma_wea : 4'h0);
                    total++;
                    if (mem_wea !== ew || mem_adr !== (dma_gnt ? dma_adr : cpu_adr)) begin
                        bad++; $display("FAIL mem_drive: got wea %h adr %h want wea %h adr %h", mem_wea, mem_adr, ew, dma_gnt ? dma_adr : cpu_adr);
                    end
                    ec = cpu_gnt && cpu_wea == 4'h0;
                    ed = dma_gnt && dma_wea == 4'h0;
                    if (ec) sb_q.push_back({1'b0, ref_mem[cpu_adr]});
                    if (ed) sb_q.push_back({1'b1, ref_mem[dma_adr]});
                    for (int k = 0; k < 4; k++) begin
                        if (cpu_gnt && cpu_wea[k]) ref_mem[cpu_adr][k*8 +: 8] = cpu_wdata[k*8 +: 8];
                        if (dma_gnt && dma_wea[k]) ref_mem[dma_adr][k*8 +: 8] = dma_wdata[k*8 +: 8];
                    end
                    @(posedge clk);
                    #1;
                    total++;
                    if ({cpu_rvalid, dma_rvalid} !== {ec, ed}) begin bad++; $display("FAIL rvalid: got %b want %b", {cpu_rvalid, dma_rvalid}, {ec, ed}); end
                    if ((ec || ed) && sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        total++;
                        if ((cpu_rvalid || dma_rvalid) && e !== {dma_rvalid, mem_dout}) begin
                            bad++; $display("FAIL read_data: got port %b data %h want port %b data %h", dma_rvalid, mem_dout, e.port, e.data);
                        end
                    end
                end
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
